// File: rtl/pio_avalon_cmd_master.sv
// Avalon-MM initiator that turns a read/write/set/clear command stream into single
// transactions against the 8-bit PIO slave register map, one response per command.
module pio_avalon_cmd_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [2:0]  ADDR_DATA    = 3'd0,
  parameter logic [2:0]  ADDR_SET     = 3'd4,
  parameter logic [2:0]  ADDR_CLR     = 3'd5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded with that count minus one.
  localparam int unsigned WAIT_CYCLES = (READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0;
  localparam logic [1:0]  WAIT_INIT   = WAIT_CYCLES[1:0];

  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("pio_avalon_cmd_master: READ_LATENCY=%0d outside 1..4", READ_LATENCY);
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] op;
  logic [1:0] wait_cnt;

  function automatic logic [2:0] op_addr(input logic [1:0] o);
    case (o)
      OP_READ:  return ADDR_DATA;
      OP_WRITE: return ADDR_DATA;
      OP_SET:   return ADDR_SET;
      OP_CLR:   return ADDR_CLR;
      default:  return ADDR_DATA;
    endcase
  endfunction

  // Any bit above the PIO byte lane flags a malformed read.
  function automatic logic read_err(input logic [31:0] rd);
    return |rd[31:8];
  endfunction

  // Command FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op             <= OP_READ;
      wait_cnt       <= 2'd0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 8'h00;
      rsp_err        <= 1'b0;
      avm_address    <= 3'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state          <= S_ISSUE;
            op             <= cmd_op;
            cmd_ready      <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_address    <= op_addr(cmd_op);
            avm_write_n    <= (cmd_op == OP_READ);
            avm_writedata  <= (cmd_op == OP_READ) ? 32'h0000_0000 : {24'h00_0000, cmd_data};
          end
        end
        S_ISSUE: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          avm_writedata  <= 32'h0000_0000;
          if (op == OP_READ) begin
            wait_cnt <= WAIT_INIT;
            state    <= (READ_LATENCY > 1) ? S_WAIT : S_CAPT;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_CAPT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= avm_readdata[7:0];
          rsp_err   <= read_err(avm_readdata);
          state     <= S_RESP;
        end
        S_RESP: begin
          // Response registers hold until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state          <= S_IDLE;
          cmd_ready      <= 1'b0;
          rsp_valid      <= 1'b0;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          avm_writedata  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_avalon_cmd_master.sv
// Directed bench: instance 0 uses READ_LATENCY=1, instance 1 READ_LATENCY=3, each
// against a small PIO slave model whose readdata is valid only READ_LATENCY cycles after select.
module tb_pio_avalon_cmd_master;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cmd_valid [N];
  logic        cmd_ready [N];
  logic [1:0]  cmd_op [N];
  logic [7:0]  cmd_data [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [7:0]  rsp_data [N];
  logic        rsp_err [N];
  logic [2:0]  avm_address [N];
  logic        avm_chipselect [N];
  logic        avm_write_n [N];
  logic [31:0] avm_writedata [N];
  logic [31:0] avm_readdata [N];
  logic [7:0]  in_port [N];
  logic [7:0]  out_port [N];
  logic        ovr_en [N];
  logic [31:0] ovr_val [N];

  int checks = 0;
  int passes = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned RL = (g == 0) ? 1 : 3;
    logic [31:0] pend;
    int          age;
    logic [7:0]  port;

    pio_avalon_cmd_master #(.READ_LATENCY(RL)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_op(cmd_op[g]), .cmd_data(cmd_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g]),
      .avm_address(avm_address[g]), .avm_chipselect(avm_chipselect[g]),
      .avm_write_n(avm_write_n[g]), .avm_writedata(avm_writedata[g]),
      .avm_readdata(avm_readdata[g])
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pend <= 32'h0;
        age  <= 0;
        port <= 8'h00;
      end else if (avm_chipselect[g] && !avm_write_n[g]) begin
        case (avm_address[g])
          3'd0:    port <= avm_writedata[g][7:0];
          3'd4:    port <= port | avm_writedata[g][7:0];
          3'd5:    port <= port & ~avm_writedata[g][7:0];
          default: port <= port;
        endcase
        age <= 0;
      end else if (avm_chipselect[g]) begin
        pend <= ovr_en[g] ? ovr_val[g] : {24'h0, in_port[g]};
        age  <= 1;
      end else if (age != 0 && age < 7) begin
        age <= age + 1;
      end
    end

    assign avm_readdata[g] = (age == RL) ? pend : 32'h00FF_00EE;
    assign out_port[g]     = port;
  end

  task automatic send(input int g, input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    cmd_valid[g] = 1'b1; cmd_op[g] = o; cmd_data[g] = d;
    for (int n = 0; n < 20; n++) begin
      if (cmd_ready[g]) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid[g] = 1'b0;
  endtask

  // k=1 is the cycle after the accept edge; stops at the first rsp_valid cycle.
  task automatic collect(input int g, output int lat, output int cs_cnt, output int cs_k,
                         output logic [35:0] bus);
    lat = -1; cs_cnt = 0; cs_k = -1; bus = 36'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (avm_chipselect[g]) begin
        cs_cnt++; cs_k = k;
        bus = {avm_address[g], avm_write_n[g], avm_writedata[g]};
      end
      if (rsp_valid[g]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_rsp(input int g);
    rsp_ready[g] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[g] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid[g], cmd_ready[g]} !== 2'b01)
      $display("FAIL handshake g%0d: rsp_valid,cmd_ready=%b required 01", g, {rsp_valid[g], cmd_ready[g]});
    else passes++;
  endtask

  task automatic check_txn(input string name, input int g, input int lat, input int cs_cnt,
                           input int cs_k, input logic [35:0] bus, input int exp_lat,
                           input logic [35:0] exp_bus, input logic [8:0] exp_rsp);
    checks++;
    if (cs_cnt !== 1 || cs_k !== 1)
      $display("FAIL %s_cs g%0d: cs cycles=%0d at k=%0d required 1 at k=1", name, g, cs_cnt, cs_k);
    else passes++;
    checks++;
    if (bus !== exp_bus)
      $display("FAIL %s_bus g%0d: addr/wn/wdata=%h required %h", name, g, bus, exp_bus);
    else passes++;
    checks++;
    if (lat !== exp_lat)
      $display("FAIL %s_lat g%0d: latency=%0d required %0d", name, g, lat, exp_lat);
    else passes++;
    checks++;
    if ({rsp_data[g], rsp_err[g]} !== exp_rsp)
      $display("FAIL %s_rsp g%0d: data,err=%h required %h", name, g, {rsp_data[g], rsp_err[g]}, exp_rsp);
    else passes++;
  endtask

  task automatic check_reset_values(input string name, input int g);
    logic [47:0] obs;
    obs = {cmd_ready[g], rsp_valid[g], rsp_data[g], rsp_err[g], avm_chipselect[g],
           avm_write_n[g], avm_address[g], avm_writedata[g]};
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0})
      $display("FAIL %s g%0d: outputs=%h required %h", name, g, obs,
               {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0});
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) check_reset_values("reset", g);
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready[0] !== 1'b0) $display("FAIL ready_early: cmd_ready=%b required 0", cmd_ready[0]);
    else passes++;
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1) $display("FAIL ready_rise: cmd_ready=%b required 1", cmd_ready[0]);
    else passes++;
  endtask

  task automatic test_write();
    int lat, cs_cnt, cs_k; logic [35:0] bus;
    send(0, 2'b01, 8'hA5);
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("write", 0, lat, cs_cnt, cs_k, bus, 2, {3'd0, 1'b0, 32'h0000_00A5}, 9'h000);
    finish_rsp(0);
    checks++;
    if (out_port[0] !== 8'hA5) $display("FAIL write_port: out_port=%h required a5", out_port[0]);
    else passes++;
  endtask

  task automatic test_set_clear();
    int lat, cs_cnt, cs_k; logic [35:0] bus;
    send(0, 2'b10, 8'h0F);
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("set", 0, lat, cs_cnt, cs_k, bus, 2, {3'd4, 1'b0, 32'h0000_000F}, 9'h000);
    finish_rsp(0);
    send(0, 2'b11, 8'h03);
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("clear", 0, lat, cs_cnt, cs_k, bus, 2, {3'd5, 1'b0, 32'h0000_0003}, 9'h000);
    finish_rsp(0);
    checks++;
    if (out_port[0] !== 8'hAC) $display("FAIL setclr_port: out_port=%h required ac", out_port[0]);
    else passes++;
  endtask

  task automatic test_read();
    int lat, cs_cnt, cs_k; logic [35:0] bus;
    in_port[0] = 8'h3C; in_port[1] = 8'h3C;
    send(0, 2'b00, 8'hFF);
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("read_rl1", 0, lat, cs_cnt, cs_k, bus, 3, {3'd0, 1'b1, 32'h0}, {8'h3C, 1'b0});
    finish_rsp(0);
    send(1, 2'b00, 8'hFF);
    collect(1, lat, cs_cnt, cs_k, bus);
    check_txn("read_rl3", 1, lat, cs_cnt, cs_k, bus, 5, {3'd0, 1'b1, 32'h0}, {8'h3C, 1'b0});
    finish_rsp(1);
  endtask

  task automatic test_read_err();
    int lat, cs_cnt, cs_k; logic [35:0] bus;
    ovr_en[0] = 1'b1; ovr_val[0] = 32'h0001_0077;
    send(0, 2'b00, 8'h00);
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("read_err", 0, lat, cs_cnt, cs_k, bus, 3, {3'd0, 1'b1, 32'h0}, {8'h77, 1'b1});
    finish_rsp(0);
    ovr_en[0] = 1'b0;
  endtask

  task automatic test_back_pressure();
    int lat, cs_cnt, cs_k, bad; logic [35:0] bus;
    in_port[0] = 8'h3C;
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_data[0] = 8'h00;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin lat = k; break; end
    end
    checks++;
    if (lat !== 3) $display("FAIL bp_lat: latency=%0d required 3", lat);
    else passes++;
    in_port[0] = 8'h99;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready[0] !== 1'b0 || avm_chipselect[0] !== 1'b0 || rsp_valid[0] !== 1'b1 ||
          rsp_data[0] !== 8'h3C || rsp_err[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL bp_hold: bad cycles=%0d required 0", bad);
    else passes++;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready[0], avm_chipselect[0], rsp_valid[0]} !== 3'b100)
      $display("FAIL bp_release: ready,cs,rsp_valid=%b required 100",
               {cmd_ready[0], avm_chipselect[0], rsp_valid[0]});
    else passes++;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    collect(0, lat, cs_cnt, cs_k, bus);
    check_txn("bp_next", 0, lat, cs_cnt, cs_k, bus, 3, {3'd0, 1'b1, 32'h0}, {8'h99, 1'b0});
    finish_rsp(0);
  endtask

  task automatic test_reset_mid();
    int lat, cs_cnt, cs_k, stray; logic [35:0] bus;
    in_port[1] = 8'h42;
    send(1, 2'b00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid", 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || avm_chipselect[1] !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0 || cmd_ready[1] !== 1'b1)
      $display("FAIL reset_stray: stray cycles=%0d cmd_ready=%b required 0 and 1", stray, cmd_ready[1]);
    else passes++;
    in_port[1] = 8'h5E;
    send(1, 2'b00, 8'h00);
    collect(1, lat, cs_cnt, cs_k, bus);
    check_txn("after_reset", 1, lat, cs_cnt, cs_k, bus, 5, {3'd0, 1'b1, 32'h0}, {8'h5E, 1'b0});
    finish_rsp(1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      cmd_valid[g] = 1'b0; cmd_op[g] = 2'b00; cmd_data[g] = 8'h00;
      rsp_ready[g] = 1'b0; in_port[g] = 8'h00; ovr_en[g] = 1'b0; ovr_val[g] = 32'h0;
    end
    test_reset();
    test_write();
    test_set_clear();
    test_read();
    test_read_err();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
